boson_capture: RTL and testbench

BOSON_CAPTURE -- requirements
Module: boson_capture

---
 rtl/boson_pkg.sv | 19 +
 rtl/boson_sync.sv | 26 ++
 rtl/boson_capture.sv | 169 ++++++++++++++++
 tb/tb_boson_capture.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boson_pkg.sv
// Shared constants and types for the Boson parallel-video capture block.
package boson_pkg;

  localparam int unsigned H_ACTIVE_DEF = 320;
  localparam int unsigned V_ACTIVE_DEF = 256;

  localparam int unsigned PX_X_W = 10;
  localparam int unsigned PX_Y_W = 9;

  // Synchronizer bank layout: {CMOS_CLK, VSYNC, HSYNC, VALID, DQ[15:0]}
  localparam int unsigned SYNC_W = 20;

  typedef enum logic [1:0] {
    StWaitBlank,
    StWaitFrame,
    StInFrame
  } state_e;

endpackage

// File: rtl/boson_sync.sv
// Parameterized-width bank of 2-flop synchronizers with synchronous clear.
module boson_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] s1_q, s2_q;

  // Two-stage register chain; every bit sees identical delay.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/boson_capture.sv
// Captures a Boson camera parallel video stream into the system clock domain,
// producing per-pixel strobes with frame/line markers, coordinates and error flags.
module boson_capture
  import boson_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CMOS_CLK,
  input  logic              CMOS_VSYNC,
  input  logic              CMOS_HSYNC,
  input  logic              CMOS_VALID,
  input  logic [15:0]       CMOS_DQ,
  output logic              px_valid,
  output logic [15:0]       px_data,
  output logic              px_sof,
  output logic              px_sol,
  output logic [PX_X_W-1:0] px_x,
  output logic [PX_Y_W-1:0] px_y,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam logic [10:0] HActiveW = 11'(H_ACTIVE);
  localparam logic [9:0]  VActiveW = 10'(V_ACTIVE);

  logic [SYNC_W-1:0] raw, synced;
  logic              s_clk, s_vs, s_hs, s_va;
  logic [15:0]       s_dq;

  assign raw = {CMOS_CLK, CMOS_VSYNC, CMOS_HSYNC, CMOS_VALID, CMOS_DQ};

  boson_sync #(
    .Width(SYNC_W)
  ) u_sync (
    .clk_i  (clk),
    .reset_i(reset),
    .d_i    (raw),
    .q_o    (synced)
  );

  assign s_clk = synced[19];
  assign s_vs  = synced[18];
  assign s_hs  = synced[17];
  assign s_va  = synced[16];
  assign s_dq  = synced[15:0];

  state_e      state_q;
  logic        clk_s3_q;
  logic        hs_prev_q;
  logic        sof_pend_q, sol_pend_q;
  logic [10:0] pix_cnt_q;   // pixels in the open line, saturating
  logic [9:0]  line_cnt_q;  // lines with pixels since frame start, saturating
  logic [15:0] frame_count_q;

  logic              sample, in_frame, hs_rise, close_line, take_pix, frame_end;
  logic [10:0]       pix_cnt_nx, pix_cnt_inc;
  logic [9:0]        line_cnt_nx;
  logic [PX_X_W-1:0] px_x_nx;
  logic [PX_Y_W-1:0] px_y_nx;

  // Sample decode; a line close is folded in ahead of any pixel or frame end
  // seen on the same sample.
  always_comb begin
    sample      = s_clk & ~clk_s3_q;
    in_frame    = (state_q == StInFrame);
    hs_rise     = s_hs & ~hs_prev_q;
    close_line  = sample & in_frame & (pix_cnt_q != 11'd0) & (hs_rise | ~s_vs);
    take_pix    = sample & in_frame & s_vs & s_hs & s_va;
    frame_end   = sample & in_frame & ~s_vs;
    pix_cnt_nx  = close_line ? 11'd0 : pix_cnt_q;
    line_cnt_nx = line_cnt_q;
    if (close_line && line_cnt_q != 10'h3ff) begin
      line_cnt_nx = line_cnt_q + 10'd1;
    end
    pix_cnt_inc = (pix_cnt_nx == 11'h7ff) ? pix_cnt_nx : pix_cnt_nx + 11'd1;
    px_x_nx     = (pix_cnt_nx > 11'd1023) ? 10'h3ff : pix_cnt_nx[9:0];
    px_y_nx     = (line_cnt_nx > 10'd511) ? 9'h1ff : line_cnt_nx[8:0];
  end

  // Capture FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StWaitBlank;
      clk_s3_q      <= 1'b0;
      hs_prev_q     <= 1'b0;
      sof_pend_q    <= 1'b0;
      sol_pend_q    <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      frame_count_q <= '0;
      px_valid      <= 1'b0;
      px_data       <= '0;
      px_sof        <= 1'b0;
      px_sol        <= 1'b0;
      px_x          <= '0;
      px_y          <= '0;
      frame_done    <= 1'b0;
      line_err      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      px_valid   <= 1'b0;
      px_sof     <= 1'b0;
      px_sol     <= 1'b0;
      frame_done <= 1'b0;
      clk_s3_q   <= s_clk;
      if (sample) begin
        hs_prev_q <= s_hs;
      end

      unique case (state_q)
        StWaitBlank: begin
          // Never start mid-frame: wait until blanking is seen.
          if (sample && !s_vs) begin
            state_q <= StWaitFrame;
          end
        end
        StWaitFrame: begin
          if (sample && s_vs) begin
            state_q    <= StInFrame;
            line_cnt_q <= '0;
            pix_cnt_q  <= '0;
            sof_pend_q <= 1'b1;
            sol_pend_q <= 1'b1;
          end
        end
        StInFrame: begin
          if (sample) begin
            pix_cnt_q  <= pix_cnt_nx;
            line_cnt_q <= line_cnt_nx;
            if (close_line && pix_cnt_q != HActiveW) begin
              line_err <= 1'b1;
            end
            if (hs_rise) begin
              sol_pend_q <= 1'b1;
            end
            if (take_pix) begin
              px_valid   <= 1'b1;
              px_data    <= s_dq;
              px_sof     <= sof_pend_q;
              px_sol     <= sol_pend_q | hs_rise;
              px_x       <= px_x_nx;
              px_y       <= px_y_nx;
              pix_cnt_q  <= pix_cnt_inc;
              sof_pend_q <= 1'b0;
              sol_pend_q <= 1'b0;
            end
            if (frame_end) begin
              state_q       <= StWaitFrame;
              frame_done    <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
              if (line_cnt_nx != VActiveW) begin
                frame_err <= 1'b1;
              end
            end
          end
        end
        default: state_q <= StWaitBlank;
      endcase
    end
  end

  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_boson_capture.sv
// Directed bench for boson_capture using a reduced 8x4 frame geometry.
module tb_boson_capture;

  localparam int unsigned HA = 8;
  localparam int unsigned VA = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CMOS_CLK = 1'b0;
  logic        CMOS_VSYNC = 1'b0;
  logic        CMOS_HSYNC = 1'b1;
  logic        CMOS_VALID = 1'b0;
  logic [15:0] CMOS_DQ = '0;
  logic        px_valid, px_sof, px_sol, frame_done, line_err, frame_err;
  logic [15:0] px_data, frame_count;
  logic [9:0]  px_x;
  logic [8:0]  px_y;

  always #5 clk = ~clk;

  boson_capture #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .CMOS_CLK   (CMOS_CLK),
    .CMOS_VSYNC (CMOS_VSYNC),
    .CMOS_HSYNC (CMOS_HSYNC),
    .CMOS_VALID (CMOS_VALID),
    .CMOS_DQ    (CMOS_DQ),
    .px_valid   (px_valid),
    .px_data    (px_data),
    .px_sof     (px_sof),
    .px_sol     (px_sol),
    .px_x       (px_x),
    .px_y       (px_y),
    .frame_done (frame_done),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sof;
    logic        sol;
  } pix_t;

  pix_t q[$];
  int   done_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Record every strobe away from the active edge.
  always @(negedge clk) begin
    if (px_valid) q.push_back({px_data, px_x, px_y, px_sof, px_sol});
    if (frame_done) done_cnt++;
  end

  // One camera pixel-clock period: outputs change on the falling edge.
  task automatic cam(input logic vs, input logic hs, input logic va, input logic [15:0] dq);
    CMOS_CLK   = 1'b0;
    CMOS_VSYNC = vs;
    CMOS_HSYNC = hs;
    CMOS_VALID = va;
    CMOS_DQ    = dq;
    #18;
    CMOS_CLK = 1'b1;
    #19;
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_blank(input int n, input logic va);
    for (int i = 0; i < n; i++) cam(1'b0, 1'b1, va, 16'h5a5a);
  endtask

  // VALID is held high during the sync pulse; those samples must be dropped.
  task automatic send_line(input int y, input int npix, input logic [15:0] seed);
    cam(1'b1, 1'b0, 1'b1, 16'hdead);
    cam(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int x = 0; x < npix; x++) cam(1'b1, 1'b1, 1'b1, seed + 16'(y * 16 + x));
    cam(1'b1, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic send_frame(input int nlines, input logic [15:0] seed);
    send_blank(2, 1'b0);
    cam(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int y = 0; y < nlines; y++) send_line(y, HA, seed);
    cam(1'b1, 1'b1, 1'b0, 16'h0000);
    send_blank(2, 1'b0);
    settle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({px_valid, px_sof, px_sol, frame_done} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 0000", {px_valid, px_sof, px_sol, frame_done});
    end
    n_vec++;
    if ({px_data, px_x, px_y} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_pixel: got data=%h x=%0d y=%0d want 0", px_data, px_x, px_y);
    end
    n_vec++;
    if ({line_err, frame_err, frame_count} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_status: got le=%b fe=%b fc=%0d want 0", line_err, frame_err,
               frame_count);
    end
    reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (q.size() !== 0) begin
      n_err++;
      $display("FAIL idle_no_edges: got %0d strobes want 0", q.size());
    end
  endtask

  task automatic test_full_frame();
    int   base = q.size();
    int   d0 = done_cnt;
    pix_t exp;
    send_frame(VA, 16'h1000);
    n_vec++;
    if (q.size() - base !== HA * VA) begin
      n_err++;
      $display("FAIL full_count: got %0d want %0d", q.size() - base, HA * VA);
    end
    for (int i = 0; i < HA * VA && base + i < q.size(); i++) begin
      exp.x   = 10'(i % HA);
      exp.y   = 9'(i / HA);
      exp.d   = 16'h1000 + 16'((i / HA) * 16 + (i % HA));
      exp.sof = (i == 0);
      exp.sol = ((i % HA) == 0);
      n_vec++;
      if (q[base + i] !== exp) begin
        n_err++;
        $display("FAIL full_pix[%0d]: got %h want %h", i, q[base + i], exp);
      end
    end
    n_vec++;
    if (done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL full_done: got %0d pulses want 1", done_cnt - d0);
    end
    n_vec++;
    if ({frame_count, line_err, frame_err} !== {16'd1, 2'b00}) begin
      n_err++;
      $display("FAIL full_status: got fc=%0d le=%b fe=%b want fc=1 le=0 fe=0", frame_count,
               line_err, frame_err);
    end
  endtask

  task automatic test_blank_valid();
    int base = q.size();
    int d0 = done_cnt;
    send_blank(6, 1'b1);
    settle();
    n_vec++;
    if (q.size() - base !== 0 || done_cnt - d0 !== 0) begin
      n_err++;
      $display("FAIL blank_valid: got %0d strobes %0d done want 0 0", q.size() - base,
               done_cnt - d0);
    end
    n_vec++;
    if (frame_count !== 16'd1) begin
      n_err++;
      $display("FAIL blank_fc: got %0d want 1", frame_count);
    end
  endtask

  task automatic test_short_line();
    int base = q.size();
    int d0 = done_cnt;
    send_blank(2, 1'b0);
    cam(1'b1, 1'b1, 1'b0, 16'h0000);
    send_line(0, HA, 16'h2000);
    send_line(1, HA - 1, 16'h2000);
    settle();
    n_vec++;
    if (line_err !== 1'b0) begin
      n_err++;
      $display("FAIL short_line_open: got le=%b want 0", line_err);
    end
    send_line(2, HA, 16'h2000);
    settle();
    n_vec++;
    if (line_err !== 1'b1) begin
      n_err++;
      $display("FAIL short_line_err: got le=%b want 1", line_err);
    end
    send_line(3, HA, 16'h2000);
    cam(1'b1, 1'b1, 1'b0, 16'h0000);
    send_blank(2, 1'b0);
    settle();
    n_vec++;
    if (q.size() - base !== HA * VA - 1) begin
      n_err++;
      $display("FAIL short_line_count: got %0d want %0d", q.size() - base, HA * VA - 1);
    end
    n_vec++;
    if ({frame_err, frame_count} !== {1'b0, 16'd2} || done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL short_line_frame: got fe=%b fc=%0d done=%0d want fe=0 fc=2 done=1",
               frame_err, frame_count, done_cnt - d0);
    end
  endtask

  task automatic test_short_frame();
    int base = q.size();
    int d0 = done_cnt;
    send_frame(VA - 1, 16'h3000);
    n_vec++;
    if (frame_err !== 1'b1) begin
      n_err++;
      $display("FAIL short_frame_err: got fe=%b want 1", frame_err);
    end
    n_vec++;
    if (frame_count !== 16'd3 || done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL short_frame_fc: got fc=%0d done=%0d want fc=3 done=1", frame_count,
               done_cnt - d0);
    end
    n_vec++;
    if (q.size() - base !== HA * (VA - 1)) begin
      n_err++;
      $display("FAIL short_frame_count: got %0d want %0d", q.size() - base, HA * (VA - 1));
    end
  endtask

  task automatic test_mid_reset();
    int base;
    int d0;
    send_blank(2, 1'b0);
    cam(1'b1, 1'b1, 1'b0, 16'h0000);
    send_line(0, HA, 16'h4000);
    send_line(1, HA, 16'h4000);
    settle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({line_err, frame_err, frame_count, px_valid} !== 19'd0) begin
      n_err++;
      $display("FAIL mid_reset_clear: got le=%b fe=%b fc=%0d pv=%b want 0", line_err,
               frame_err, frame_count, px_valid);
    end
    reset = 1'b0;
    base = q.size();
    d0 = done_cnt;
    send_line(2, HA, 16'h4000);
    send_line(3, HA, 16'h4000);
    cam(1'b1, 1'b1, 1'b0, 16'h0000);
    send_blank(2, 1'b0);
    settle();
    n_vec++;
    if (q.size() - base !== 0 || done_cnt - d0 !== 0 || frame_count !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset_discard: got %0d strobes %0d done fc=%0d want 0 0 0",
               q.size() - base, done_cnt - d0, frame_count);
    end
    send_frame(VA, 16'h5000);
    n_vec++;
    if (q.size() - base !== HA * VA) begin
      n_err++;
      $display("FAIL mid_reset_count: got %0d want %0d", q.size() - base, HA * VA);
    end else begin
      n_vec++;
      if (q[base] !== {16'h5000, 10'd0, 9'd0, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL mid_reset_first: got %h want %h", q[base],
                 {16'h5000, 10'd0, 9'd0, 1'b1, 1'b1});
      end
    end
    n_vec++;
    if (frame_count !== 16'd1 || done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL mid_reset_fc: got fc=%0d done=%0d want fc=1 done=1", frame_count,
               done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    int d0 = done_cnt;
    force dut.frame_count_q = 16'hffff;
    @(negedge clk);
    release dut.frame_count_q;
    send_frame(VA, 16'h6000);
    n_vec++;
    if (frame_count !== 16'd0 || done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL wrap: got fc=%0d done=%0d want fc=0 done=1", frame_count, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_blank_valid();
    test_short_line();
    test_short_frame();
    test_mid_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
